// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffered, registered common-data-bus arbiter.
// Each result source (3..0 = ls, div, mul, alu) hands its label and data into
// a single-entry slot. One full slot is granted per cycle, and its contents
// are broadcast on BCEN/BClabel/BCdata on the following edge.
// Compile-time option: define CDB_FIXED_PRIO_EN to replace round-robin with
// fixed priority, where the highest index wins.
// Despite its name, nRST is an asynchronous, active-high reset.
//
// Handshake: source i offers a result by raising require[i] with labelIn/dataIn
// stable. The transfer happens on the rising edge where require[i] and
// requireAC[i] are both 1. requireAC[i] never depends on require[i], so a
// source that sees requireAC[i]=0 must hold its request and payload unchanged.
module cdb_arbiter #(
    parameter int N_SRC   = 4,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [N_SRC-1:0]           require,
    output logic [N_SRC-1:0]           requireAC,
    input  logic [N_SRC*LABEL_W-1:0]   labelIn,
    input  logic [N_SRC*DATA_W-1:0]    dataIn,
    output logic                       BCEN,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [DATA_W-1:0]          BCdata,
    output logic [N_SRC-1:0]           slotFull
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [LABEL_W-1:0] slot_label [N_SRC];
    logic [DATA_W-1:0]  slot_data  [N_SRC];
    logic [N_SRC-1:0]   slot_full;
    logic [N_SRC-1:0]   grant;
    logic [N_SRC-1:0]   accept;
    logic [N_SRC-1:0]   capture;
    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;

`ifndef CDB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr;
    int                 scan_sum;
    logic [IDX_W-1:0]   scan_idx;

    // Round-robin pick: the first full slot at or after rr_ptr, wrapping around.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = 0;
        scan_idx  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= N_SRC) begin
                scan_sum = scan_sum - N_SRC;
            end
            scan_idx = IDX_W'(scan_sum);
            if (!grant_any && slot_full[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to the slot after the winner; it holds while the bus is idle.
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (grant_idx == IDX_W'(N_SRC - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end
`else
    // Fixed priority: the later (higher-index) full slot overrides, so ls wins over alu.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (slot_full[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end
`endif

    // Accept into an empty slot, or into the slot being drained this cycle (same-edge refill).
    always_comb begin
        accept  = {N_SRC{~nRST}} & (~slot_full | grant);
        capture = require & accept;
    end

    assign requireAC = accept;
    assign slotFull  = slot_full;

    // Slot update: a capture loads the payload; a grant without a refill empties the slot.
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            slot_full <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_label[i] <= '0;
                slot_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (capture[i]) begin
                    slot_label[i] <= labelIn[i*LABEL_W +: LABEL_W];
                    slot_data[i]  <= dataIn[i*DATA_W +: DATA_W];
                    // A zero label means the result has no consumer, so it is dropped.
                    slot_full[i]  <= |labelIn[i*LABEL_W +: LABEL_W];
                end else if (grant[i]) begin
                    slot_full[i]  <= 1'b0;
                end
            end
        end
    end

    // Registered broadcast of the granted slot; the bus reads as all zeros while idle.
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            BCEN    <= 1'b0;
            BClabel <= '0;
            BCdata  <= '0;
        end else if (grant_any) begin
            BCEN    <= 1'b1;
            BClabel <= slot_label[grant_idx];
            BCdata  <= slot_data[grant_idx];
        end else begin
            BCEN    <= 1'b0;
            BClabel <= '0;
            BCdata  <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter.
// Expected broadcasts ({label, data}) are queued when a request is driven.
// A negedge monitor pops one entry and compares it each time BCEN is high.
module tb_cdb_arbiter;

    localparam int N_SRC   = 4;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 4;
    localparam int W       = LABEL_W + DATA_W;

    logic                     clk;
    logic                     nRST;
    logic [N_SRC-1:0]         require;
    logic [N_SRC-1:0]         requireAC;
    logic [N_SRC*LABEL_W-1:0] labelIn;
    logic [N_SRC*DATA_W-1:0]  dataIn;
    logic                     BCEN;
    logic [LABEL_W-1:0]       BClabel;
    logic [DATA_W-1:0]        BCdata;
    logic [N_SRC-1:0]         slotFull;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .require   (require),
        .requireAC (requireAC),
        .labelIn   (labelIn),
        .dataIn    (dataIn),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .slotFull  (slotFull)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int src, input logic [LABEL_W-1:0] lbl, input logic [DATA_W-1:0] dat);
        require[src]                     = 1'b1;
        labelIn[src*LABEL_W +: LABEL_W]  = lbl;
        dataIn[src*DATA_W +: DATA_W]     = dat;
    endtask

    task automatic expect_bc(input logic [LABEL_W-1:0] lbl, input logic [DATA_W-1:0] dat);
        exp_q.push_back({lbl, dat});
    endtask

    // Scoreboard monitor: every broadcast must match the oldest expected entry.
    always @(negedge clk) begin
        if (!nRST) begin
            if (BCEN) begin
                if (exp_q.size() == 0) begin
                    check("bc_unexpected", {BClabel, BCdata}, '0);
                end else begin
                    check("bc_payload", {BClabel, BCdata}, exp_q.pop_front());
                end
            end else begin
                check("bc_idle_zero", {BClabel, BCdata}, '0);
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] d;
        require = '0;
        labelIn = '0;
        dataIn  = '0;
        nRST    = 1'b1;

        // Reset holds requireAC low even with every source requesting
        require = 4'b1111;
        labelIn = 16'h4321;
        dataIn  = {32'h4, 32'h3, 32'h2, 32'h1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_requireAC", requireAC, 4'b0000);
        check("rst_bcen", BCEN, 1'b0);
        check("rst_slotfull", slotFull, 4'b0000);
        tick();
        require = '0;
        labelIn = '0;
        dataIn  = '0;
        nRST    = 1'b0;

        // Single alu result: BCEN exactly two cycles after require, for one cycle
        tick();
        drive(0, 4'h3, 32'h0000_00AA);
        expect_bc(4'h3, 32'h0000_00AA);
        @(negedge clk);
        check("single_ac", requireAC[0], 1'b1);
        tick();
        require = '0;
        @(negedge clk);
        check("single_t1_bcen", BCEN, 1'b0);
        check("single_t1_full", slotFull, 4'b0001);
        tick();
        @(negedge clk);
        check("single_t2_bcen", BCEN, 1'b1);
        check("single_t2_label", BClabel, 4'h3);
        check("single_t2_data", BCdata, 32'h0000_00AA);
        tick();
        @(negedge clk);
        check("single_t3_bcen", BCEN, 1'b0);

        // Reset pulse so that the round-robin pointer is back at alu
        tick();
        nRST = 1'b1;
        tick();
        nRST = 1'b0;

        // Contention: all four sources request in the same cycle
        tick();
        for (int s = 0; s < N_SRC; s++) begin
            drive(s, LABEL_W'(s + 1), DATA_W'((s + 1) * 16));
        end
`ifdef CDB_FIXED_PRIO_EN
        for (int s = N_SRC - 1; s >= 0; s--) begin
            expect_bc(LABEL_W'(s + 1), DATA_W'((s + 1) * 16));
        end
`else
        for (int s = 0; s < N_SRC; s++) begin
            expect_bc(LABEL_W'(s + 1), DATA_W'((s + 1) * 16));
        end
`endif
        @(negedge clk);
        check("cont_ac", requireAC, 4'b1111);
        tick();
        require = '0;
        @(negedge clk);
        check("cont_full", slotFull, 4'b1111);
        for (int k = 0; k < N_SRC; k++) begin
            tick();
            @(negedge clk);
            check("cont_bcen", BCEN, 1'b1);
        end
        tick();
        @(negedge clk);
        check("cont_done_bcen", BCEN, 1'b0);

        // Back-to-back: mul streams five results with labels 5..9
        tick();
        for (int j = 0; j < 5; j++) begin
            d = DATA_W'($urandom_range(32'h0000_FFFF, 0));
            drive(1, LABEL_W'(5 + j), d);
            expect_bc(LABEL_W'(5 + j), d);
            @(negedge clk);
            check("b2b_ac", requireAC[1], 1'b1);
            if (j >= 2) begin
                check("b2b_bcen", BCEN, 1'b1);
            end
            tick();
        end
        require = '0;
        @(negedge clk);
        check("b2b_bcen_t5", BCEN, 1'b1);
        tick();
        @(negedge clk);
        check("b2b_bcen_t6", BCEN, 1'b1);
        tick();
        @(negedge clk);
        check("b2b_bcen_t7", BCEN, 1'b0);

        // One div result moves the round-robin pointer to ls
        tick();
        drive(2, 4'hD, 32'h0000_0D00);
        expect_bc(4'hD, 32'h0000_0D00);
        tick();
        require = '0;
        tick();
        tick();

        // Backpressure: div waits behind ls while offering a second result
        drive(2, 4'hA, 32'h0000_A000);
        drive(3, 4'hB, 32'h0000_B000);
        expect_bc(4'hB, 32'h0000_B000);
        expect_bc(4'hA, 32'h0000_A000);
        expect_bc(4'hC, 32'h0000_C000);
        @(negedge clk);
        check("bp_ac_both", requireAC[3:2], 2'b11);
        tick();
        require[3] = 1'b0;
        drive(2, 4'hC, 32'h0000_C000);
        @(negedge clk);
        check("bp_div_blocked", requireAC[2], 1'b0);
        check("bp_full", slotFull, 4'b1100);
        tick();
        @(negedge clk);
        check("bp_div_granted_ac", requireAC[2], 1'b1);
        check("bp_ls_bcen", BCEN, 1'b1);
        tick();
        require = '0;
        @(negedge clk);
        check("bp_div1_bcen", BCEN, 1'b1);
        tick();
        @(negedge clk);
        check("bp_div2_bcen", BCEN, 1'b1);
        tick();
        @(negedge clk);
        check("bp_done_bcen", BCEN, 1'b0);

        // Label zero: the handshake completes but nothing is stored or broadcast
        tick();
        drive(0, 4'h0, 32'h0000_DEAD);
        @(negedge clk);
        check("lz_ac", requireAC[0], 1'b1);
        tick();
        require = '0;
        @(negedge clk);
        check("lz_full", slotFull, 4'b0000);
        tick();
        @(negedge clk);
        check("lz_bcen", BCEN, 1'b0);

        // Reset mid-operation discards buffered results
        tick();
        drive(0, 4'h1, 32'h0000_0111);
        drive(1, 4'h2, 32'h0000_0222);
        tick();
        require = '0;
        check("mid_full_before", slotFull, 4'b0011);
        nRST = 1'b1;
        #1;
        check("mid_full_async", slotFull, 4'b0000);
        check("mid_ac_in_reset", requireAC, 4'b0000);
        tick();
        nRST = 1'b0;
        @(negedge clk);
        check("mid_bcen_after", BCEN, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        check("mid_no_stale", BCEN, 1'b0);
        check("mid_full_after", slotFull, 4'b0000);

        // Every queued result must have been broadcast
        repeat (2) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
